// File: rtl/riscv_mem_responder_pkg.sv
// rtl/riscv_mem_responder_pkg.sv - shared state encodings and constants for the memory responder
package riscv_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/riscv_mem_responder_ram.sv
// rtl/riscv_mem_responder_ram.sv - word RAM with combinational read and synchronous write
module riscv_ram #(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  // Contents are deliberately left unreset; a load or store defines them.
  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/riscv_mem_responder.sv
// rtl/riscv_mem_responder.sv - program loader plus instruction/data memories for a RISC-V core
module riscv_mem_responder
  import riscv_mem_responder_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_write_data,
  input  logic        i_mem_write,
  output logic [31:0] o_read_data,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [31:0] i_ld_data,
  input  logic        i_ld_last,
  input  logic        i_ld_restart,
  output logic        o_core_rst_n,
  output logic        o_misaligned
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IAW-1:0]   r_ptr;
  logic [IAW-1:0]   w_ptr_nxt;
  logic             r_core_rst_n;
  logic             r_misaligned;
  logic             w_misaligned_nxt;
  logic             w_ld_fire;
  logic             w_ptr_end;
  logic             w_dmem_we;
  logic [31:0]      w_imem_rdata;
  logic [31:0]      w_dmem_rdata;

  assign w_ld_fire = (r_state == ST_LOAD) && i_ld_valid;
  assign w_ptr_end = (r_ptr == IAW'(IMEM_WORDS - 1));
  assign w_dmem_we = (r_state == ST_RUN) && i_mem_write;

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_misaligned_nxt = r_misaligned;
    case (r_state)
      ST_LOAD: begin
        if (w_ld_fire) begin
          // The final slot ends the load without wrapping the pointer.
          if (i_ld_last || w_ptr_end) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_ptr_nxt = r_ptr + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_mem_write && (i_data_addr[1:0] != 2'b00)) begin
          w_misaligned_nxt = 1'b1;
        end
        if (i_ld_restart) begin
          w_state_nxt      = ST_LOAD;
          w_ptr_nxt        = '0;
          w_misaligned_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_LOAD;
      r_ptr        <= '0;
      r_core_rst_n <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      // Core reset tracks the state being entered, so it rises with the first RUN cycle.
      r_core_rst_n <= (w_state_nxt == ST_RUN);
      r_misaligned <= w_misaligned_nxt;
    end
  end

  riscv_ram #(
    .DEPTH (IMEM_WORDS)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (w_ld_fire),
    .i_waddr (r_ptr),
    .i_wdata (i_ld_data),
    .i_raddr (i_pc[IAW+1:2]),
    .o_rdata (w_imem_rdata)
  );

  riscv_ram #(
    .DEPTH (DMEM_WORDS)
  ) u_dmem (
    .i_clk   (i_clk),
    .i_we    (w_dmem_we),
    .i_waddr (i_data_addr[DAW+1:2]),
    .i_wdata (i_write_data),
    .i_raddr (i_data_addr[DAW+1:2]),
    .o_rdata (w_dmem_rdata)
  );

  assign o_instr      = (r_state == ST_RUN) ? w_imem_rdata : NOP_INSTR;
  assign o_read_data  = w_dmem_rdata;
  assign o_ld_ready   = (r_state == ST_LOAD);
  assign o_core_rst_n = r_core_rst_n;
  assign o_misaligned = r_misaligned;

  // Address bits outside the word index alias by design.
  logic w_unused;
  assign w_unused = ^{i_pc[31:IAW+2], i_pc[1:0], i_data_addr[31:DAW+2]};

endmodule

// File: tb/tb_riscv_mem_responder.sv
// tb/tb_riscv_mem_responder.sv - self-checking bench for riscv_mem_responder
module tb_riscv_mem_responder;

  localparam int IW = 256;
  localparam int DW = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic [31:0] data_addr = '0;
  logic [31:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic [31:0] read_data;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_restart = 1'b0;
  logic        core_rst_n;
  logic        misaligned;

  always #5 clk = ~clk;

  riscv_mem_responder #(
    .IMEM_WORDS (IW),
    .DMEM_WORDS (DW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pc         (pc),
    .o_instr      (instr),
    .i_data_addr  (data_addr),
    .i_write_data (write_data),
    .i_mem_write  (mem_write),
    .o_read_data  (read_data),
    .i_ld_valid   (ld_valid),
    .o_ld_ready   (ld_ready),
    .i_ld_data    (ld_data),
    .i_ld_last    (ld_last),
    .i_ld_restart (ld_restart),
    .o_core_rst_n (core_rst_n),
    .o_misaligned (misaligned)
  );

  // Behavioural model: what the core should observe, phase by phase.
  logic [31:0] m_imem [IW];
  bit          m_ik   [IW];
  logic [31:0] m_dmem [DW];
  bit          m_dk   [DW];
  bit m_loading = 1'b1;
  bit m_drain   = 1'b0;
  bit m_running = 1'b0;
  bit m_mis     = 1'b0;
  int m_ptr     = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1'b1; m_drain = 1'b0; m_running = 1'b0; m_mis = 1'b0; m_ptr = 0;
    end else if (m_loading) begin
      if (ld_valid) begin
        m_imem[m_ptr] = ld_data;
        m_ik[m_ptr] = 1'b1;
        if (ld_last || m_ptr == IW - 1) begin
          m_loading = 1'b0; m_drain = 1'b1;
        end else begin
          m_ptr = m_ptr + 1;
        end
      end
    end else if (m_drain) begin
      m_drain = 1'b0; m_running = 1'b1;
    end else begin
      if (mem_write) begin
        int di;
        di = int'((data_addr >> 2) % DW);
        m_dmem[di] = write_data;
        m_dk[di] = 1'b1;
        if (data_addr % 4 != 0) m_mis = 1'b1;
      end
      if (ld_restart) begin
        m_running = 1'b0; m_loading = 1'b1; m_ptr = 0; m_mis = 1'b0;
      end
    end
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  string       lit_nm  [128];
  int          lit_sel [128];
  logic [31:0] lit_exp [128];
  int          lit_seq  = 0;
  int          lit_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int ii;
      int di;
      logic [31:0] a;
      ii = int'((pc >> 2) % IW);
      di = int'((data_addr >> 2) % DW);
      chk("ld_ready", {31'b0, ld_ready}, {31'b0, m_loading});
      chk("core_rst_n", {31'b0, core_rst_n}, {31'b0, m_running});
      chk("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
      if (!m_running) chk("instr_nop", instr, NOP);
      else if (m_ik[ii]) chk("instr", instr, m_imem[ii]);
      if (m_dk[di]) chk("read_data", read_data, m_dmem[di]);
      while (lit_seen < lit_seq) begin
        case (lit_sel[lit_seen])
          0:       a = instr;
          1:       a = read_data;
          2:       a = {31'b0, core_rst_n};
          3:       a = {31'b0, ld_ready};
          default: a = {31'b0, misaligned};
        endcase
        chk(lit_nm[lit_seen], a, lit_exp[lit_seen]);
        lit_seen = lit_seen + 1;
      end
    end
  end

  task automatic lit(input string nm, input int sel, input logic [31:0] exp);
    lit_nm[lit_seq]  = nm;
    lit_sel[lit_seq] = sel;
    lit_exp[lit_seq] = exp;
    lit_seq = lit_seq + 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] prog [3];

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    step();
    step();
    lit("rst_ld_ready", 3, 32'd1);
    lit("rst_core_rst_n", 2, 32'd0);
    lit("rst_misaligned", 4, 32'd0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pc = 32'h8;
    lit("load_instr_nop", 0, NOP);
    lit("load_core_rst_n", 2, 32'd0);
    step();
    pc = 32'h1234;
    ld_restart = 1'b1;
    lit("load_instr_nop2", 0, NOP);
    for (int i = 0; i < 3; i++) begin
      step();
      ld_restart = 1'b0;
      ld_valid = 1'b1;
      ld_data = prog[i];
      ld_last = (i == 2);
    end
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    lit("drain_core_rst_n", 2, 32'd0);
    lit("drain_ld_ready", 3, 32'd0);
    step();
    pc = 32'h8;
    lit("run_core_rst_n", 2, 32'd1);
    lit("run_instr_pc8", 0, 32'h0020_81B3);
    step();
    pc = 32'h0; ld_valid = 1'b1; ld_data = 32'hFFFF_FFFF;
    lit("run_instr_pc0", 0, 32'h0050_0093);
    lit("run_ld_ready", 3, 32'd0);
    step();
    ld_valid = 1'b0; pc = 32'h4;
    lit("run_instr_pc4", 0, 32'h00A0_0113);
    step();
    mem_write = 1'b1; data_addr = 32'h10; write_data = 32'h1111_1111;
    step();
    write_data = 32'hDEAD_BEEF;
    lit("same_cycle_old", 1, 32'h1111_1111);
    step();
    mem_write = 1'b0;
    lit("next_cycle_new", 1, 32'hDEAD_BEEF);
    step();
    data_addr = 32'h410;
    lit("alias_0x410", 1, 32'hDEAD_BEEF);
    step();
    mem_write = 1'b1; data_addr = 32'h13; write_data = 32'hCAFE_F00D;
    lit("mis_before", 4, 32'd0);
    step();
    mem_write = 1'b0; data_addr = 32'h10;
    lit("mis_word4", 1, 32'hCAFE_F00D);
    lit("mis_set", 4, 32'd1);
    step();
    ld_restart = 1'b1;
    lit("restart_cycle_rst", 2, 32'd1);
    lit("mis_sticky", 4, 32'd1);
    step();
    ld_restart = 1'b0;
    lit("restart_mis_clr", 4, 32'd0);
    lit("restart_core_rst", 2, 32'd0);
    lit("restart_ld_ready", 3, 32'd1);
    lit("restart_instr_nop", 0, NOP);
    mem_write = 1'b1; write_data = 32'h5555_5555; ld_restart = 1'b1;
    step();
    mem_write = 1'b0; ld_restart = 1'b0;
    lit("load_store_dropped", 1, 32'hCAFE_F00D);
    lit("load_restart_ign", 3, 32'd1);
    for (int i = 0; i < IW; i++) begin
      step();
      ld_valid = 1'b1;
      ld_data = 32'h1000_0000 + 32'(i * 7);
    end
    step();
    ld_data = 32'hBAD0_BAD0;
    lit("beat257_ready", 3, 32'd0);
    lit("full_drain_rst", 2, 32'd0);
    step();
    pc = 32'h3FC;
    lit("full_run_rst", 2, 32'd1);
    lit("full_last_word", 0, 32'h1000_0000 + 32'(255 * 7));
    step();
    ld_valid = 1'b0; pc = 32'h400;
    lit("full_alias_0", 0, 32'h1000_0000);
    for (int k = 0; k < 16; k++) begin
      step();
      pc = 32'(k * 68 + 2);
    end
    step();
    ld_restart = 1'b1;
    step();
    ld_restart = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      ld_valid = 1'b1; ld_data = 32'hA000_0000 + 32'(i);
    end
    step();
    ld_valid = 1'b0;
    rst_n = 1'b0;
    lit("midload_rst_ready", 3, 32'd1);
    lit("midload_rst_core", 2, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      ld_valid = 1'b1; ld_data = 32'hB000_0000 + 32'(i); ld_last = (i == 4);
    end
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
    step();
    pc = 32'h0;
    lit("reload_word0", 0, 32'hB000_0000);
    step();
    pc = 32'h4;
    lit("reload_word1", 0, 32'hB000_0001);
    step();
    pc = 32'h14;
    lit("reload_keep5", 0, 32'h1000_0000 + 32'(5 * 7));
    for (int k = 0; k < 8; k++) begin
      step();
      pc = 32'(k * 4);
    end
    step();
    step();
    chk_en = 1'b0;
    if (lit_seen != lit_seq) begin
      errors = errors + 1;
      $display("FAIL lit_pending: got %0d expected %0d", lit_seen, lit_seq);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
